// File: rtl/dram_responder.sv
// dram_responder: MEM-stage data memory with a fixed access latency, pipeline stall flag and RV32I sub-word loads/stores.
// Optional feature: define DRAM_MISALIGN_TRAP_EN to flag and suppress misaligned half/word accesses.
module dram_responder #(
  parameter int MEM_DELAY = 4,
  parameter int DEPTH_LOG = 10,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dram_re,
  input  logic            dram_we,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            mem_stall,
  output logic            misalign
);

  localparam int         AW       = DEPTH_LOG + 2;
  localparam int         WORDS    = 1 << DEPTH_LOG;
  localparam logic [3:0] LAST_CNT = 4'(MEM_DELAY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic            r_store;
  logic [XLEN-1:0] r_rdata;
  logic            r_rvalid;
  logic            r_misalign;
  logic [31:0]     r_mem [WORDS];

  logic            w_req;
  logic            w_accept;
  logic            w_in_wait;
  logic            w_enter_done;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_wdata;
  logic [2:0]      w_funct3;
  logic            w_store;
  logic            w_load_ok;
  logic            w_store_ok;
  logic            w_legal;
  logic            w_misal;
  logic [31:0]     w_rd_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic [3:0]      w_be;
  logic [31:0]     w_wr_data;
  logic            w_we;
  logic            w_unused;

  // Addresses wrap modulo the array size, so the upper address bits carry no meaning here.
  assign w_unused = ^addr[XLEN-1:AW];

  assign w_req     = dram_re | dram_we;
  assign w_in_wait = (r_state == WAIT);
  assign w_accept  = w_req && !w_in_wait;
  assign mem_stall = w_in_wait || w_accept;

  // With a one-cycle latency the access completes on the acceptance edge, before anything is latched.
  assign w_enter_done = (w_in_wait && (r_cnt == LAST_CNT)) ||
                        ((MEM_DELAY == 1) && w_accept);

  assign w_addr   = w_in_wait ? r_addr   : addr[AW-1:0];
  assign w_wdata  = w_in_wait ? r_wdata  : wdata[31:0];
  assign w_funct3 = w_in_wait ? r_funct3 : funct3;
  assign w_store  = w_in_wait ? r_store  : dram_we;

  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first, so no latch is inferred.
    w_load_ok  = 1'b0;
    w_store_ok = 1'b0;
    case (w_funct3)
      3'b000, 3'b001, 3'b010: begin
        w_load_ok  = 1'b1;
        w_store_ok = 1'b1;
      end
      3'b100, 3'b101: w_load_ok = 1'b1;
      default: ;
    endcase
  end

  assign w_legal = w_store ? w_store_ok : w_load_ok;

`ifdef DRAM_MISALIGN_TRAP_EN
  assign w_misal = w_legal &&
                   (((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00)));
`else
  // Half and word lanes are selected by addr[1] / not at all, which forces natural alignment.
  assign w_misal = 1'b0;
`endif

  assign w_rd_word = r_mem[w_addr[AW-1:2]];
  assign w_byte    = w_rd_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_half    = w_rd_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = '0;
    case (w_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b010:  w_load_data = XLEN'(w_rd_word);
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = '0;
    endcase
    if (w_misal) w_load_data = '0;
  end

  always_comb begin
    w_be      = 4'b0000;
    w_wr_data = '0;
    case (w_funct3)
      3'b000: begin
        w_be      = 4'b0001 << w_addr[1:0];
        w_wr_data = {4{w_wdata[7:0]}};
      end
      3'b001: begin
        w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{w_wdata[15:0]}};
      end
      3'b010: begin
        w_be      = 4'b1111;
        w_wr_data = w_wdata;
      end
      default: ;
    endcase
  end

  // The rst term drops a store whose commit edge coincides with reset.
  assign w_we = w_enter_done && w_store && !w_misal && !rst;

  // NOTE: the array has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_addr[AW-1:2]][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= 3'b000;
      r_store    <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      // NOTE: state registers use <= so every update samples the values from before the edge.
      r_rvalid   <= w_enter_done;
      r_misalign <= w_enter_done && w_misal;
      if (w_enter_done && !w_store) r_rdata <= w_load_data;

      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_addr   <= addr[AW-1:0];
            r_wdata  <= wdata[31:0];
            r_funct3 <= funct3;
            r_store  <= dram_we;
            if (MEM_DELAY == 1) begin
              r_state <= DONE;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'd1;
            end
          end else begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: scoreboard of expected completions plus per-scenario timing checks.
module tb_dram_responder;

  localparam int MEM_DELAY = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        misal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_re, dram_we;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        rvalid, mem_stall, misalign;

  logic        d1_re, d1_we;
  logic [31:0] d1_addr, d1_wdata;
  logic [2:0]  d1_funct3;
  logic [31:0] d1_rdata;
  logic        d1_rvalid, d1_mem_stall, d1_misalign;

  int    n_pass  = 0;
  int    n_total = 0;
  exp_t  sb_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;

  always #5 clk = ~clk;

  dram_responder #(.MEM_DELAY(MEM_DELAY), .DEPTH_LOG(10), .XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .dram_re(dram_re), .dram_we(dram_we), .addr(addr),
    .wdata(wdata), .funct3(funct3), .rdata(rdata), .rvalid(rvalid),
    .mem_stall(mem_stall), .misalign(misalign)
  );

  dram_responder #(.MEM_DELAY(1), .DEPTH_LOG(10), .XLEN(32)) u_dut1 (
    .clk(clk), .rst(rst), .dram_re(d1_re), .dram_we(d1_we), .addr(d1_addr),
    .wdata(d1_wdata), .funct3(d1_funct3), .rdata(d1_rdata), .rvalid(d1_rvalid),
    .mem_stall(d1_mem_stall), .misalign(d1_misalign)
  );

  // Scoreboard: every completion pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_rvalid: rvalid=1 with no access outstanding");
      end else begin
        mon_e = sb_q.pop_front();
        mon_n = name_q.pop_front();
        n_total++;
        if (rdata !== mon_e.rdata)
          $display("FAIL %s_rdata: got %h expected %h", mon_n, rdata, mon_e.rdata);
        else n_pass++;
        n_total++;
        if (misalign !== mon_e.misal)
          $display("FAIL %s_misalign: got %b expected %b", mon_n, misalign, mon_e.misal);
        else n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Issues one access at the current cycle T and returns in its completion cycle.
  task automatic do_access(input logic re, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] exp_rd, input logic exp_mis, input string name);
    int   cycles;
    int   stalls;
    exp_t e;
    dram_re = re; dram_we = we; addr = a; wdata = wd; funct3 = f3;
    e.rdata = exp_rd;
    e.misal = exp_mis;
    sb_q.push_back(e);
    name_q.push_back(name);
    #1;
    stalls = (mem_stall === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    dram_re = 1'b0; dram_we = 1'b0;
    addr = 32'hFFFF_FFFE; wdata = $urandom; funct3 = 3'b111;
    cycles = 1;
    while (rvalid !== 1'b1 && cycles < 20) begin
      if (mem_stall === 1'b1) stalls++;
      @(posedge clk); #1;
      cycles++;
    end
    n_total++;
    if (cycles != MEM_DELAY) $display("FAIL %s_latency: got %0d cycles expected %0d", name, cycles, MEM_DELAY);
    else n_pass++;
    n_total++;
    if (stalls != MEM_DELAY) $display("FAIL %s_stall_len: got %0d cycles expected %0d", name, stalls, MEM_DELAY);
    else n_pass++;
    n_total++;
    if (mem_stall !== 1'b0) $display("FAIL %s_stall_done: got %b expected 0", name, mem_stall);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (rvalid !== 1'b0)    $display("FAIL reset_rvalid: got %b expected 0", rvalid);       else n_pass++;
    n_total++; if (rdata !== 32'h0)    $display("FAIL reset_rdata: got %h expected 0", rdata);         else n_pass++;
    n_total++; if (misalign !== 1'b0)  $display("FAIL reset_misalign: got %b expected 0", misalign);   else n_pass++;
    n_total++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", mem_stall);     else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    do_access(1'b0, 1'b1, 32'h10, 32'h1122_3344, 3'b010, 32'h0, 1'b0, "pre_sw");
    idle_cycle();
    rst = 1'b1;
    repeat (2) idle_cycle();
    rst = 1'b0;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1122_3344, 1'b0, "lw_after_rst");
    idle_cycle();
    dram_we = 1'b1; addr = 32'h10; wdata = 32'h5555_5555; funct3 = 3'b010;
    sb_q.push_back('0);
    name_q.push_back("aborted_sw");
    @(posedge clk); #1;
    dram_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    name_q.delete();
    n_total++; if (mem_stall !== 1'b0) $display("FAIL abort_stall: got %b expected 0", mem_stall); else n_pass++;
    n_total++; if (rvalid !== 1'b0)    $display("FAIL abort_rvalid: got %b expected 0", rvalid);   else n_pass++;
    n_total++; if (rdata !== 32'h0)    $display("FAIL abort_rdata: got %h expected 0", rdata);     else n_pass++;
    idle_cycle();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rvalid === 1'b1) seen = 1'b1;
      idle_cycle();
    end
    n_total++; if (seen) $display("FAIL abort_no_rvalid: got rvalid pulse expected none"); else n_pass++;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1122_3344, 1'b0, "lw_no_write");
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010, 32'h1122_3344, 1'b0, "sw_20");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_20_b2b");
    idle_cycle();
  endtask

  task automatic test_extension();
    do_access(1'b1, 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0, "lb_23");
    do_access(1'b1, 1'b0, 32'h23, 32'h0, 3'b100, 32'h0000_00DE, 1'b0, "lbu_23");
    do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF_DEAD, 1'b0, "lh_22");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0, "lhu_20");
    idle_cycle();
  endtask

  task automatic test_partial_store();
    do_access(1'b0, 1'b1, 32'h21, 32'h1234_5677, 3'b000, 32'h0000_BEEF, 1'b0, "sb_21");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hDEAD_77EF, 1'b0, "lw_after_sb");
    do_access(1'b0, 1'b1, 32'h22, 32'hFFFF_1234, 3'b001, 32'hDEAD_77EF, 1'b0, "sh_22");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234_77EF, 1'b0, "lw_after_sh");
    idle_cycle();
  endtask

  task automatic test_strobe_conflict_wrap();
    do_access(1'b1, 1'b1, 32'h1000, 32'hA5A5_A5A5, 3'b010, 32'h1234_77EF, 1'b0, "sw_conflict");
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'hA5A5_A5A5, 1'b0, "lw_wrap");
    idle_cycle();
  endtask

  task automatic test_illegal_funct3();
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 3'b011, 32'h0, 1'b0, "ld_f3_011");
    do_access(1'b0, 1'b1, 32'h0, 32'h0, 3'b100, 32'h0, 1'b0, "st_f3_100");
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'hA5A5_A5A5, 1'b0, "lw_after_illegal");
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 3'b110, 32'h0, 1'b0, "ld_f3_110");
    idle_cycle();
  endtask

  task automatic test_misalign();
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0, "sw_cafe");
`ifdef DRAM_MISALIGN_TRAP_EN
    do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b010, 32'h0, 1'b1, "lw_mis_22");
    do_access(1'b1, 1'b0, 32'h21, 32'h0, 3'b001, 32'h0, 1'b1, "lh_mis_21");
    do_access(1'b0, 1'b1, 32'h22, 32'h1234_5678, 3'b010, 32'h0, 1'b1, "sw_mis_22");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, "lw_mem_kept");
`else
    do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, "lw_mis_22");
    do_access(1'b1, 1'b0, 32'h21, 32'h0, 3'b001, 32'hFFFF_F00D, 1'b0, "lh_mis_21");
    do_access(1'b0, 1'b1, 32'h22, 32'h1234_5678, 3'b010, 32'hFFFF_F00D, 1'b0, "sw_mis_22");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234_5678, 1'b0, "lw_aligned_write");
`endif
    idle_cycle();
  endtask

  task automatic test_delay_one();
    d1_we = 1'b1; d1_re = 1'b0; d1_addr = 32'h40; d1_wdata = 32'h0BAD_F00D; d1_funct3 = 3'b010;
    #1;
    n_total++; if (d1_mem_stall !== 1'b1) $display("FAIL d1_sw_stall: got %b expected 1", d1_mem_stall); else n_pass++;
    @(posedge clk); #1;
    d1_we = 1'b0; d1_re = 1'b1; d1_wdata = 32'h0;
    #1;
    n_total++; if (d1_rvalid !== 1'b1)    $display("FAIL d1_sw_rvalid: got %b expected 1", d1_rvalid);       else n_pass++;
    n_total++; if (d1_mem_stall !== 1'b1) $display("FAIL d1_lw_stall: got %b expected 1", d1_mem_stall);    else n_pass++;
    @(posedge clk); #1;
    d1_re = 1'b0; d1_addr = 32'h0;
    #1;
    n_total++; if (d1_rvalid !== 1'b1)        $display("FAIL d1_lw_rvalid: got %b expected 1", d1_rvalid);     else n_pass++;
    n_total++; if (d1_rdata !== 32'h0BAD_F00D) $display("FAIL d1_lw_rdata: got %h expected 0badf00d", d1_rdata); else n_pass++;
    n_total++; if (d1_mem_stall !== 1'b0)     $display("FAIL d1_stall_release: got %b expected 0", d1_mem_stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (d1_rvalid !== 1'b0)        $display("FAIL d1_rvalid_single: got %b expected 0", d1_rvalid); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    dram_re = 1'b0; dram_we = 1'b0; addr = '0; wdata = '0; funct3 = 3'b000;
    d1_re = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0; d1_funct3 = 3'b000;
    test_reset();
    test_reset_mid_access();
    test_back_to_back();
    test_extension();
    test_partial_store();
    test_strobe_conflict_wrap();
    test_illegal_funct3();
    test_misalign();
    test_delay_one();
    repeat (2) idle_cycle();
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
